// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan path: the segment table used
// by both the driver encoder and the scan decoder, slot FSM states and the
// blank segment pattern.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } slot_state_t;

    // abcdefg, active-low, segment a in bit 6
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational segment decoder: active-low abcdefg pattern to hex digit,
// with flags for a legal hex glyph and for the all-off blank pattern.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       valid,
    output logic       blank
);

    // Table search; the sixteen glyphs are distinct so at most one entry hits
    always_comb begin
        hex   = 4'h0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                hex   = 4'(i);
                valid = 1'b1;
            end
        end
        blank = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive side of the multiplexed 8-digit seven-segment bus. Follows the
// anode scan, samples the cathodes once per slot after a settle delay and
// commits a digit after MATCH_COUNT consecutive identical decodes.
// Optional build macro BLANK_DETECT_EN: accept the all-off pattern as a
// blank symbol that invalidates the digit instead of flagging a code error.
//
// state  | meaning
// IDLE   | no single anode active, waiting for a one-hot-low anode
// SETTLE | anode selected, waiting SETTLE_CYCLES for cathodes to settle
// SAMPLE | one cycle: decode cathodes and run match/commit for slot_idx
// HOLD   | slot already sampled, waiting for the anode to move on
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MATCH_COUNT    = 2,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  An,
    input  logic [7:0]  Cath,
    output logic [31:0] digit_hex,
    output logic [7:0]  digit_dp,
    output logic [7:0]  digit_valid,
    output logic        update_pulse,
    output logic [2:0]  update_idx,
    output logic        code_err,
    output logic        link_alive
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    MATCH_TGT    = 4'(MATCH_COUNT);
`ifdef BLANK_DETECT_EN
    localparam logic BLANK_ACCEPT = 1'b1;
`else
    localparam logic BLANK_ACCEPT = 1'b0;
`endif

    logic [7:0]    an_s1, an_s2, cath_s1, cath_s2;
    logic [7:0]    an_act;
    logic          an_onehot;
    logic [2:0]    an_idx;

    slot_state_t   state, state_nxt;
    logic [2:0]    slot_idx, slot_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;

    logic [TW-1:0] timer;
    logic          timeout_evt;

    logic [3:0]    dec_hex;
    logic          dec_valid, dec_blank;
    logic          dp_lit, sym_blank, sym_ok, reach, changed;
    logic [5:0]    cur_key, new_key;
    logic [3:0]    cnt_cur, cnt_new;

    logic [3:0]    cand_hex   [8];
    logic          cand_dp    [8];
    logic          cand_blank [8];
    logic [3:0]    match_cnt  [8];

    // Two-flop synchronizers; idle value is all lines high (nothing driven)
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_s1   <= 8'hFF;
            an_s2   <= 8'hFF;
            cath_s1 <= 8'hFF;
            cath_s2 <= 8'hFF;
        end else begin
            an_s1   <= An;
            an_s2   <= an_s1;
            cath_s1 <= Cath;
            cath_s2 <= cath_s1;
        end
    end

    assign an_act    = ~an_s2;
    assign an_onehot = (an_act != 8'd0) && ((an_act & (an_act - 8'd1)) == 8'd0);

    // Index of the active anode, meaningful only when an_onehot
    always_comb begin
        an_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_act[i]) an_idx = 3'(i);
        end
    end

    // Slot FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            slot_idx   <= 3'd0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            slot_idx   <= slot_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    // Slot FSM next state; an anode change restarts the settle from zero
    always_comb begin
        state_nxt  = state;
        slot_nxt   = slot_idx;
        settle_nxt = settle_cnt;
        if (state == ST_IDLE) begin
            if (an_onehot) begin
                state_nxt  = ST_SETTLE;
                slot_nxt   = an_idx;
                settle_nxt = '0;
            end
        end else if (!an_onehot) begin
            state_nxt = ST_IDLE;
        end else if (an_idx != slot_idx) begin
            state_nxt  = ST_SETTLE;
            slot_nxt   = an_idx;
            settle_nxt = '0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state_nxt  = ST_SAMPLE;
                    else                           settle_nxt = settle_cnt + 1'b1;
                end
                ST_SAMPLE: state_nxt = ST_HOLD;
                default:   state_nxt = state;
            endcase
        end
    end

    ssd_seg_decode u_seg_decode (
        .seg   (cath_s2[7:1]),
        .hex   (dec_hex),
        .valid (dec_valid),
        .blank (dec_blank)
    );

    // Candidate comparison for the slot under sample; blank carries its own key bit
    always_comb begin
        dp_lit    = ~cath_s2[0];
        sym_blank = BLANK_ACCEPT & dec_blank;
        sym_ok    = dec_valid | sym_blank;
        cur_key   = {cand_blank[slot_idx], cand_hex[slot_idx], cand_dp[slot_idx]};
        new_key   = {sym_blank, (sym_blank ? 4'h0 : dec_hex), dp_lit};
        cnt_cur   = match_cnt[slot_idx];
        if (new_key == cur_key) cnt_new = (cnt_cur == 4'hF) ? 4'hF : cnt_cur + 4'd1;
        else                    cnt_new = 4'd1;
        reach     = (cnt_new >= MATCH_TGT);
        changed   = !digit_valid[slot_idx]
                    || (digit_hex[{slot_idx, 2'b00} +: 4] != dec_hex)
                    || (digit_dp[slot_idx] != dp_lit);
    end

    // Link timer: saturates at TIMEOUT_CYCLES while no single anode is active
    always_ff @(posedge Clk) begin
        if (Reset)                    timer <= '0;
        else if (an_onehot)           timer <= '0;
        else if (timer != TIMEOUT_MAX) timer <= timer + 1'b1;
    end

    assign timeout_evt = !an_onehot && (timer == TIMEOUT_LAST);

    // Match, commit and timeout bookkeeping; results appear the cycle after SAMPLE
    always_ff @(posedge Clk) begin
        if (Reset) begin
            digit_hex    <= '0;
            digit_dp     <= '0;
            digit_valid  <= '0;
            update_pulse <= 1'b0;
            update_idx   <= 3'd0;
            code_err     <= 1'b0;
            link_alive   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cand_hex[i]   <= 4'h0;
                cand_dp[i]    <= 1'b0;
                cand_blank[i] <= 1'b0;
                match_cnt[i]  <= 4'd0;
            end
        end else begin
            update_pulse <= 1'b0;
            code_err     <= 1'b0;
            if (timeout_evt) begin
                link_alive  <= 1'b0;
                digit_valid <= '0;
                for (int i = 0; i < 8; i++) match_cnt[i] <= 4'd0;
            end else if (state == ST_SAMPLE) begin
                link_alive <= 1'b1;
                if (!sym_ok) begin
                    code_err            <= 1'b1;
                    match_cnt[slot_idx] <= 4'd0;
                end else begin
                    cand_blank[slot_idx] <= new_key[5];
                    cand_hex[slot_idx]   <= new_key[4:1];
                    cand_dp[slot_idx]    <= new_key[0];
                    match_cnt[slot_idx]  <= cnt_new;
                    if (reach) begin
                        if (sym_blank) begin
                            digit_valid[slot_idx] <= 1'b0;
                        end else begin
                            digit_hex[{slot_idx, 2'b00} +: 4] <= dec_hex;
                            digit_dp[slot_idx]                <= dp_lit;
                            digit_valid[slot_idx]             <= 1'b1;
                            if (changed) begin
                                update_pulse <= 1'b1;
                                update_idx   <= slot_idx;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
